// File: rtl/regfile_ctrl.sv
// Sequencer for the 32x32 dual-port BRAM register file: post-reset clear sweep,
// write-priority arbitration of rs1/rs2 reads vs rd writes, x0-forced operands.

module regfile_opnd (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cap_i,
  input  logic        vld_i,
  input  logic [4:0]  idx_i,
  input  logic [31:0] dout_i,
  output logic [31:0] data_o
);
  logic        zero_q;
  logic [31:0] hold_q;
  logic [31:0] live;

  assign live   = zero_q ? 32'd0 : dout_i;
  // A write right after a return disturbs the RAM output, so the return is held here.
  assign data_o = vld_i ? live : hold_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      zero_q <= 1'b1;
      hold_q <= 32'd0;
    end else begin
      if (cap_i) zero_q <= (idx_i == 5'd0);
      if (vld_i) hold_q <= live;
    end
  end
endmodule

module regfile_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rd_req,
  input  logic [4:0]  rd_rs1,
  input  logic [4:0]  rd_rs2,
  output logic        rd_ready,
  output logic        rvalid,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wr_req,
  input  logic [4:0]  wr_rd,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic        busy,
  output logic [4:0]  ram_ada,
  output logic [4:0]  ram_adb,
  output logic [31:0] ram_dina,
  output logic [31:0] ram_dinb,
  output logic        ram_cea,
  output logic        ram_ceb,
  output logic        ram_wrea,
  output logic        ram_wreb,
  output logic        ram_rst,
  input  logic [31:0] ram_douta,
  input  logic [31:0] ram_doutb
);
  localparam int NUM_OPND = 2;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rvalid_q;
  logic       run, rd_acc;

  logic [NUM_OPND-1:0][4:0]  opnd_idx;
  logic [NUM_OPND-1:0][31:0] opnd_dout;
  logic [NUM_OPND-1:0][31:0] opnd_data;

  assign run      = resetn & (state_q == ST_RUN);
  assign wr_ready = run;
  assign rd_ready = run & ~wr_req;
  assign rd_acc   = rd_req & rd_ready;
  assign busy     = (state_q == ST_INIT);
  assign rvalid   = rvalid_q;
  assign ram_rst  = ~resetn;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_INIT;
      cnt_q    <= 4'd0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rd_acc;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) state_d = ST_RUN;
    end
  end

  // Both ports clear an even/odd pair per sweep cycle; in RUN a write owns port A alone.
  always_comb begin
    ram_ada  = 5'd0;
    ram_adb  = 5'd0;
    ram_dina = 32'd0;
    ram_dinb = 32'd0;
    ram_cea  = 1'b0;
    ram_ceb  = 1'b0;
    ram_wrea = 1'b0;
    ram_wreb = 1'b0;
    if (resetn) begin
      case (state_q)
        ST_INIT: begin
          ram_ada  = {cnt_q, 1'b0};
          ram_adb  = {cnt_q, 1'b1};
          ram_cea  = 1'b1;
          ram_ceb  = 1'b1;
          ram_wrea = 1'b1;
          ram_wreb = 1'b1;
        end
        ST_RUN: begin
          if (wr_req) begin
            ram_ada  = wr_rd;
            ram_dina = wr_data;
            ram_cea  = 1'b1;
            ram_wrea = (wr_rd != 5'd0);
          end else if (rd_req) begin
            ram_ada = rd_rs1;
            ram_adb = rd_rs2;
            ram_cea = 1'b1;
            ram_ceb = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign opnd_idx  = {rd_rs2, rd_rs1};
  assign opnd_dout = {ram_doutb, ram_douta};

  for (genvar g = 0; g < NUM_OPND; g++) begin : g_opnd
    regfile_opnd u_opnd (
      .clk    (clk),
      .resetn (resetn),
      .cap_i  (rd_acc),
      .vld_i  (rvalid_q),
      .idx_i  (opnd_idx[g]),
      .dout_i (opnd_dout[g]),
      .data_o (opnd_data[g])
    );
  end

  assign rs1_data = opnd_data[0];
  assign rs2_data = opnd_data[1];
endmodule

// File: tb/tb_regfile_ctrl.sv
// Randomized + directed bench for regfile_ctrl with a behavioural RAM and an
// array-based register-file reference model feeding a return scoreboard.

module tb_regfile_ctrl;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rd_req = 1'b0;
  logic [4:0]  rd_rs1 = 5'd0, rd_rs2 = 5'd0;
  logic        rd_ready, rvalid;
  logic [31:0] rs1_data, rs2_data;
  logic        wr_req = 1'b0;
  logic [4:0]  wr_rd = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_ready, busy;
  logic [4:0]  ram_ada, ram_adb;
  logic [31:0] ram_dina, ram_dinb;
  logic        ram_cea, ram_ceb, ram_wrea, ram_wreb, ram_rst;
  logic [31:0] ram_douta = 32'd0, ram_doutb = 32'd0;

  always #5 clk = ~clk;

  regfile_ctrl dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_rs1(rd_rs1), .rd_rs2(rd_rs2), .rd_ready(rd_ready),
    .rvalid(rvalid), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wr_req(wr_req), .wr_rd(wr_rd), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy),
    .ram_ada(ram_ada), .ram_adb(ram_adb), .ram_dina(ram_dina), .ram_dinb(ram_dinb),
    .ram_cea(ram_cea), .ram_ceb(ram_ceb), .ram_wrea(ram_wrea), .ram_wreb(ram_wreb),
    .ram_rst(ram_rst), .ram_douta(ram_douta), .ram_doutb(ram_doutb)
  );

  // Dual-port BRAM: 1-cycle read, write-first, output held while ce is low.
  logic [31:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = $urandom;
  always @(posedge clk) begin
    if (ram_rst) begin
      ram_douta <= 32'd0;
      ram_doutb <= 32'd0;
    end else begin
      if (ram_cea) begin
        if (ram_wrea) mem[ram_ada] <= ram_dina;
        ram_douta <= ram_wrea ? ram_dina : mem[ram_ada];
      end
      if (ram_ceb) begin
        if (ram_wreb) mem[ram_adb] <= ram_dinb;
        ram_doutb <= ram_wreb ? ram_dinb : mem[ram_adb];
      end
    end
  end

  int          n_chk = 0, n_fail = 0;
  logic [31:0] ref_rf [32];
  logic [63:0] exp_q [$];
  int          init_left = 16;
  bit          started = 0, have_last = 0;
  logic [63:0] last_ret;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: drive, check handshake/RAM controls, advance the reference model.
  task automatic cycle(input bit rstn, input bit rq, input logic [4:0] a1, input logic [4:0] a2,
                       input bit wq, input logic [4:0] wd, input logic [31:0] wdat);
    bit bsy;
    @(negedge clk);
    resetn = rstn; rd_req = rq; rd_rs1 = a1; rd_rs2 = a2;
    wr_req = wq; wr_rd = wd; wr_data = wdat;
    #1;
    if (!rstn) begin
      check("rst_ready", {rd_ready, wr_ready}, 2'b00);
      check("rst_ram_en", {ram_cea, ram_ceb, ram_wrea, ram_wreb}, 4'b0000);
      check("rst_ram_rst", ram_rst, 1'b1);
      exp_q.delete();
      init_left = 16;
      for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
      have_last = 0;
      started = 1;
    end else begin
      bsy = (init_left > 0);
      check("busy", busy, bsy);
      check("wr_ready", wr_ready, !bsy);
      check("rd_ready", rd_ready, !bsy && !wq);
      if (!bsy && wq) begin
        check("wr_port", {ram_cea, ram_wrea, ram_ceb, ram_ada, ram_dina},
              {1'b1, wd != 5'd0, 1'b0, wd, wdat});
        if (wd != 5'd0) ref_rf[wd] = wdat;
      end else if (!bsy && rq) begin
        exp_q.push_back({(a2 == 5'd0) ? 32'd0 : ref_rf[a2], (a1 == 5'd0) ? 32'd0 : ref_rf[a1]});
      end
      if (init_left > 0) init_left--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 5'd0, 5'd0, 0, 5'd0, 32'd0);
  endtask

  // Monitor: every return must match the oldest expected operand pair; idle cycles hold it.
  initial begin
    logic [63:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (started) begin
        check("rvalid", rvalid, exp_q.size() > 0);
        if (rvalid && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rs1_data", rs1_data, e[31:0]);
          check("rs2_data", rs2_data, e[63:32]);
          last_ret = e;
          have_last = 1;
        end else if (!rvalid && have_last) begin
          check("hold", {rs2_data, rs1_data}, last_ret);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] a, b;
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    idle(18);
    // Reset and clear
    cycle(1, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cycle(1, 1, 5'd5, 5'd31, 1, 5'd9, 32'h1111);
    cycle(1, 1, 5'd5, 5'd31, 0, 0, 0);
    idle(2);
    // Basic R/W and read-after-write
    cycle(1, 0, 0, 0, 1, 5'd3, 32'h12345678);
    cycle(1, 0, 0, 0, 1, 5'd4, 32'hCAFEF00D);
    cycle(1, 1, 5'd3, 5'd4, 0, 0, 0);
    idle(2);
    // x0
    cycle(1, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    cycle(1, 1, 5'd0, 5'd0, 0, 0, 0);
    idle(2);
    // Collision
    cycle(1, 1, 5'd7, 5'd3, 1, 5'd7, 32'hA5A5A5A5);
    cycle(1, 1, 5'd7, 5'd3, 0, 0, 0);
    idle(2);
    // Stream hold: fill, 8 back-to-back reads, write on the last return
    for (int i = 1; i < 32; i++) cycle(1, 0, 0, 0, 1, i[4:0], $urandom);
    for (int i = 0; i < 8; i++) cycle(1, 1, 5'(i + 8), 5'(i + 16), 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 5'd15, 32'h0BADF00D);
    idle(4);
    // Mid-read reset
    cycle(1, 1, 5'd3, 5'd4, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    idle(18);
    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 249) != 0), ($urandom_range(0, 2) != 0), a, b,
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom);
    end
    idle(3);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
